// File: rtl/atm_bank_host.sv
// Bank-side responder for the ATM controller: holds per-account balance, PIN,
// failed-attempt counter and lock flag, and services one request at a time.
module atm_bank_host #(
  parameter int unsigned      NUM_ACCT  = 4,
  parameter int unsigned      BAL_W     = 6,
  parameter int unsigned      PIN_W     = 4,
  parameter logic [PIN_W-1:0] DEF_PIN   = PIN_W'(4'b0110),
  parameter logic [BAL_W-1:0] INIT_BAL  = '0,
  parameter int unsigned      MAX_TRIES = 3,
  localparam int unsigned     AW        = (NUM_ACCT > 1) ? $clog2(NUM_ACCT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AW-1:0]    req_acct,
  input  logic [PIN_W-1:0] req_pin,
  input  logic [BAL_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_status,
  output logic [BAL_W-1:0] rsp_balance,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_acct,
  input  logic [PIN_W-1:0] cfg_pin,
  input  logic [BAL_W-1:0] cfg_bal
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  localparam logic [1:0] OP_DEP  = 2'b00;
  localparam logic [1:0] OP_WDR  = 2'b10;

  localparam logic [2:0] ST_OK       = 3'b000;
  localparam logic [2:0] ST_BAD_PIN  = 3'b001;
  localparam logic [2:0] ST_LOCKED   = 3'b010;
  localparam logic [2:0] ST_NO_FUNDS = 3'b011;
  localparam logic [2:0] ST_OVERFLOW = 3'b100;
  localparam logic [2:0] ST_ZERO_AMT = 3'b101;
  localparam logic [2:0] ST_BAD_ACCT = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_RESP} state_t;

  state_t state_q, state_d;

  // Latched request
  logic [1:0]       op_q;
  logic [AW-1:0]    acct_q;
  logic [PIN_W-1:0] pin_q;
  logic [BAL_W-1:0] amt_q;

  // Result of the CHECK stage carried into EXEC
  logic             chk_ok_q;
  logic [2:0]       chk_status_q;

  // Account store
  logic [BAL_W-1:0] bal_q   [NUM_ACCT];
  logic [PIN_W-1:0] pin_m_q [NUM_ACCT];
  logic [TW-1:0]    tries_q [NUM_ACCT];
  logic [NUM_ACCT-1:0] lock_q;

  logic             acct_ok_c, cfg_ok_c;
  logic [BAL_W-1:0] cur_bal_c;
  logic [PIN_W-1:0] cur_pin_c;
  logic [TW-1:0]    cur_tries_c, tries_inc_c;
  logic             cur_lock_c;
  logic             chk_ok_c;
  logic [2:0]       chk_status_c;
  logic [BAL_W:0]   sum_c;
  logic [2:0]       exec_status_c;
  logic [BAL_W-1:0] exec_bal_c;
  logic             bal_we_c;

  assign req_ready = (state_q == S_IDLE) && !cfg_we;

  // Account lookup for the latched request; out-of-range reads return zero
  always_comb begin
    acct_ok_c   = ({1'b0, acct_q} < (AW+1)'(NUM_ACCT));
    cfg_ok_c    = ({1'b0, cfg_acct} < (AW+1)'(NUM_ACCT));
    cur_bal_c   = '0;
    cur_pin_c   = '0;
    cur_tries_c = '0;
    cur_lock_c  = 1'b0;
    if (acct_ok_c) begin
      cur_bal_c   = bal_q[acct_q];
      cur_pin_c   = pin_m_q[acct_q];
      cur_tries_c = tries_q[acct_q];
      cur_lock_c  = lock_q[acct_q];
    end
    tries_inc_c = cur_tries_c + TW'(1);
  end

  // Authentication check in priority order
  always_comb begin
    chk_ok_c     = 1'b0;
    chk_status_c = ST_OK;
    if (!acct_ok_c)              chk_status_c = ST_BAD_ACCT;
    else if (cur_lock_c)         chk_status_c = ST_LOCKED;
    else if (pin_q != cur_pin_c) chk_status_c = ST_BAD_PIN;
    else                         chk_ok_c     = 1'b1;
  end

  // Arithmetic for an authenticated request; never wraps
  always_comb begin
    sum_c         = {1'b0, cur_bal_c} + {1'b0, amt_q};
    exec_status_c = ST_OK;
    exec_bal_c    = cur_bal_c;
    bal_we_c      = 1'b0;
    case (op_q)
      OP_DEP: begin
        if (amt_q == '0)       exec_status_c = ST_ZERO_AMT;
        else if (sum_c[BAL_W]) exec_status_c = ST_OVERFLOW;
        else begin
          exec_bal_c = sum_c[BAL_W-1:0];
          bal_we_c   = 1'b1;
        end
      end
      OP_WDR: begin
        if (amt_q == '0)             exec_status_c = ST_ZERO_AMT;
        else if (amt_q > cur_bal_c)  exec_status_c = ST_NO_FUNDS;
        else begin
          exec_bal_c = cur_bal_c - amt_q;
          bal_we_c   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid && req_ready) state_d = S_CHECK;
      S_CHECK: state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_valid && rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, account store and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_DEP;
      acct_q       <= '0;
      pin_q        <= '0;
      amt_q        <= '0;
      chk_ok_q     <= 1'b0;
      chk_status_q <= ST_OK;
      rsp_valid    <= 1'b0;
      rsp_status   <= ST_OK;
      rsp_balance  <= '0;
      bal_q        <= '{default: INIT_BAL};
      pin_m_q      <= '{default: DEF_PIN};
      tries_q      <= '{default: '0};
      lock_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_we) begin
            if (cfg_ok_c) begin
              bal_q[cfg_acct]   <= cfg_bal;
              pin_m_q[cfg_acct] <= cfg_pin;
              tries_q[cfg_acct] <= '0;
              lock_q[cfg_acct]  <= 1'b0;
            end
          end else if (req_valid) begin
            op_q   <= req_op;
            acct_q <= req_acct;
            pin_q  <= req_pin;
            amt_q  <= req_amount;
          end
        end
        S_CHECK: begin
          chk_ok_q     <= chk_ok_c;
          chk_status_q <= chk_status_c;
          if (acct_ok_c && !cur_lock_c) begin
            if (pin_q != cur_pin_c) begin
              tries_q[acct_q] <= tries_inc_c;
              if (tries_inc_c >= TW'(MAX_TRIES)) lock_q[acct_q] <= 1'b1;
            end else begin
              tries_q[acct_q] <= '0;
            end
          end
        end
        S_EXEC: begin
          if (chk_ok_q) begin
            rsp_status  <= exec_status_c;
            rsp_balance <= exec_bal_c;
            if (bal_we_c) bal_q[acct_q] <= exec_bal_c;
          end else begin
            rsp_status  <= chk_status_q;
            rsp_balance <= '0;
          end
        end
        S_RESP: begin
          if (!rsp_valid)     rsp_valid <= 1'b1;
          else if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_bank_host.sv
// Directed bench for atm_bank_host: a reference model pushes expected responses
// into a scoreboard queue, popped and compared when rsp_valid is seen.
module tb_atm_bank_host;

  localparam logic [1:0] OP_DEP = 2'b00, OP_BAL = 2'b01, OP_WDR = 2'b10, OP_AUTH = 2'b11;
  localparam logic [2:0] ST_OK = 3'b000, ST_BAD_PIN = 3'b001, ST_LOCKED = 3'b010,
                         ST_NO_FUNDS = 3'b011, ST_OVERFLOW = 3'b100, ST_ZERO_AMT = 3'b101,
                         ST_BAD_ACCT = 3'b110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [1:0] req_acct;
  logic [3:0] req_pin;
  logic [5:0] req_amount;
  logic       rsp_valid, rsp_ready;
  logic [2:0] rsp_status;
  logic [5:0] rsp_balance;
  logic       cfg_we;
  logic [1:0] cfg_acct;
  logic [3:0] cfg_pin;
  logic [5:0] cfg_bal;

  typedef struct packed { logic [2:0] st; logic [5:0] bal; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  int         m_bal   [4];
  logic [3:0] m_pin   [4];
  int         m_tries [4];
  bit         m_lock  [4];

  atm_bank_host dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acct(req_acct), .req_pin(req_pin), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance),
    .cfg_we(cfg_we), .cfg_acct(cfg_acct), .cfg_pin(cfg_pin), .cfg_bal(cfg_bal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bal[i] = 0; m_pin[i] = 4'b0110; m_tries[i] = 0; m_lock[i] = 1'b0;
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [1:0] acct,
                       input logic [3:0] pin, input logic [5:0] amt, output exp_t e);
    int a;
    a = int'(acct);
    e.st = ST_OK; e.bal = 6'd0;
    if (a >= 4) e.st = ST_BAD_ACCT;
    else if (m_lock[a]) e.st = ST_LOCKED;
    else if (pin != m_pin[a]) begin
      e.st = ST_BAD_PIN;
      m_tries[a]++;
      if (m_tries[a] >= 3) m_lock[a] = 1'b1;
    end else begin
      m_tries[a] = 0;
      if (op == OP_DEP) begin
        if (amt == 0) e.st = ST_ZERO_AMT;
        else if (m_bal[a] + int'(amt) > 63) e.st = ST_OVERFLOW;
        else m_bal[a] = m_bal[a] + int'(amt);
      end else if (op == OP_WDR) begin
        if (amt == 0) e.st = ST_ZERO_AMT;
        else if (int'(amt) > m_bal[a]) e.st = ST_NO_FUNDS;
        else m_bal[a] = m_bal[a] - int'(amt);
      end
      e.bal = 6'(m_bal[a]);
    end
  endtask

  // One full transaction; hold=1 stalls the response for 5 cycles
  task automatic send(input logic [1:0] op, input logic [1:0] acct, input logic [3:0] pin,
                      input logic [5:0] amt, input bit hold);
    int   lat, w;
    exp_t e;
    logic [2:0] st_h;
    logic [5:0] bal_h;
    @(negedge clk);
    rsp_ready  = !hold;
    req_op = op; req_acct = acct; req_pin = pin; req_amount = amt; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    model(op, acct, pin, amt, e);
    sb.push_back(e);
    #1 req_valid = 1'b0;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("rsp_latency", 32'(lat), 32'd3);
    e = sb.pop_front();
    chk("rsp_status", 32'(rsp_status), 32'(e.st));
    chk("rsp_balance", 32'(rsp_balance), 32'(e.bal));
    if (hold) begin
      st_h = rsp_status; bal_h = rsp_balance;
      repeat (5) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_status", 32'(rsp_status), 32'(st_h));
        chk("hold_balance", 32'(rsp_balance), 32'(bal_h));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic cfg(input logic [1:0] acct, input logic [3:0] pin, input logic [5:0] bal);
    @(negedge clk);
    cfg_we = 1'b1; cfg_acct = acct; cfg_pin = pin; cfg_bal = bal;
    req_valid = 1'b1; req_op = OP_BAL; req_acct = acct; req_pin = pin; req_amount = 6'd0;
    #1 chk("cfg_blocks_req", 32'(req_ready), 32'd0);
    @(posedge clk);
    m_pin[acct] = pin; m_bal[acct] = int'(bal); m_tries[acct] = 0; m_lock[acct] = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_acct = 2'd0; req_pin = 4'd0;
    req_amount = 6'd0; rsp_ready = 1'b1; cfg_we = 1'b0; cfg_acct = 2'd0; cfg_pin = 4'd0;
    cfg_bal = 6'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_status", 32'(rsp_status), 32'd0);
    chk("reset_rsp_balance", 32'(rsp_balance), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    send(OP_AUTH, 2'd0, 4'b0110, 6'd0, 1'b0);

    send(OP_DEP, 2'd1, 4'b0110, 6'd40, 1'b0);
    send(OP_DEP, 2'd1, 4'b0110, 6'd30, 1'b0);
    send(OP_WDR, 2'd1, 4'b0110, 6'd41, 1'b0);
    send(OP_WDR, 2'd1, 4'b0110, 6'd40, 1'b0);
    send(OP_WDR, 2'd1, 4'b0110, 6'd0, 1'b0);

    repeat (3) send(OP_AUTH, 2'd2, 4'b0000, 6'd0, 1'b0);
    send(OP_BAL, 2'd2, 4'b0110, 6'd0, 1'b0);
    cfg(2'd2, 4'b1010, 6'd5);
    send(OP_AUTH, 2'd2, 4'b1010, 6'd0, 1'b0);

    send(OP_AUTH, 2'd3, 4'b0001, 6'd0, 1'b0);
    send(OP_AUTH, 2'd3, 4'b0001, 6'd0, 1'b0);
    send(OP_AUTH, 2'd3, 4'b0110, 6'd0, 1'b0);
    send(OP_AUTH, 2'd3, 4'b1111, 6'd0, 1'b0);
    send(OP_AUTH, 2'd3, 4'b1111, 6'd0, 1'b0);
    send(OP_DEP, 2'd3, 4'b0110, 6'd63, 1'b0);
    send(OP_DEP, 2'd3, 4'b0110, 6'd1, 1'b0);

    send(OP_BAL, 2'd2, 4'b1010, 6'd0, 1'b1);

    // Reset while a deposit sits in EXEC
    @(negedge clk);
    req_op = OP_DEP; req_acct = 2'd2; req_pin = 4'b1010; req_amount = 6'd10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    send(OP_AUTH, 2'd2, 4'b0110, 6'd0, 1'b0);
    send(OP_BAL, 2'd1, 4'b0110, 6'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/atm_bank_host.md
Name: atm_bank_host

Overview:
- Bank-side responder for the ATM transaction controller. Services authenticate, deposit, withdraw and balance-inquiry requests over a valid/ready request channel and a valid/ready response channel.
- Holds per-account balance, PIN, failed-attempt counter and lock flag in registers.
- Sits between the ATM front-end FSM and the account store. It is the single authority for balances and PIN checks.

Parameters:
- NUM_ACCT, 4, number of accounts; account index width AW = clog2(NUM_ACCT), minimum 1.
- BAL_W, 6, balance and amount width.
- PIN_W, 4, PIN width.
- DEF_PIN, 4'b0110, PIN of every account after reset.
- INIT_BAL, 0, balance of every account after reset.
- MAX_TRIES, 3, consecutive PIN failures that lock an account.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  host can accept a request.
- req_op  in  2  00 deposit, 10 withdraw, 01 balance, 11 auth-only.
- req_acct  in  AW  account index.
- req_pin  in  PIN_W  PIN presented with the request.
- req_amount  in  BAL_W  amount for deposit/withdraw; ignored otherwise.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_status  out  3  result code (see below).
- rsp_balance  out  BAL_W  balance after the operation.
- cfg_we  in  1  account programming strobe.
- cfg_acct  in  AW  account to program.
- cfg_pin  in  PIN_W  new PIN.
- cfg_bal  in  BAL_W  new balance.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; rsp_valid=0, rsp_status=000, rsp_balance=0.
  - All balances = INIT_BAL, PINs = DEF_PIN, try counters = 0, lock flags = 0.
  - Reset mid-transaction aborts it with no balance change.
- Status codes:
  - 000 OK, 001 BAD_PIN, 010 LOCKED, 011 NO_FUNDS, 100 OVERFLOW, 101 ZERO_AMT, 110 BAD_ACCT.
- FSM IDLE -> CHECK -> EXEC -> RESP -> IDLE:
  - req_ready = (state==IDLE) && !cfg_we, combinational.
  - IDLE: on req_valid && req_ready, latch op/acct/pin/amount and go to CHECK.
  - CHECK: evaluate in priority order:
    - acct >= NUM_ACCT: BAD_ACCT.
    - Account locked: LOCKED; try counter unchanged.
    - PIN mismatch: BAD_PIN; try counter +1; when the counter reaches MAX_TRIES, set lock on the same edge.
    - Otherwise: clear try counter and proceed.
  - EXEC, only when CHECK passed:
    - Deposit: computed in BAL_W+1 bits. Carry set -> OVERFLOW, balance unchanged. amount==0 -> ZERO_AMT.
    - Withdraw: amount==0 -> ZERO_AMT. amount > balance -> NO_FUNDS, balance unchanged. Else balance -= amount, OK.
    - Balance and auth: OK, no change.
  - RESP: rsp_valid=1; rsp_status and rsp_balance stay stable until rsp_valid && rsp_ready, then return to IDLE.
- rsp_balance value:
  - Post-operation balance for OK, NO_FUNDS, OVERFLOW and ZERO_AMT.
  - 0 for BAD_PIN, LOCKED and BAD_ACCT, so no balance is exposed without authentication.
- Latency and throughput:
  - Request accepted at edge N; rsp_valid high after edge N+3.
  - One transaction in flight; req_ready=0 from CHECK through the response handshake.
  - Back-to-back: a new request may be accepted in the cycle after the response handshake.
- Configuration:
  - cfg_we takes effect only in IDLE; it is ignored in other states.
  - Writes the PIN and balance of cfg_acct, clears its try counter and lock flag.
  - Out-of-range cfg_acct: no effect.
  - cfg_we and req_valid together in IDLE: cfg wins and the request waits (req_ready=0).
- Try counter saturates at MAX_TRIES; a locked account stays locked until cfg_we or reset.
- Arithmetic is unsigned; there is no silent wrap in either direction.

Test Plan:
- Reset, then auth acct 0 with PIN 0110 -> rsp_valid exactly 3 cycles after accept; status 000, balance 0.
- Deposit 40, then deposit 30 on acct 1 -> first OK with balance 40; second OVERFLOW (100) with balance 40.
- Balance 40: withdraw 41 -> NO_FUNDS (011), balance 40. Then withdraw 40 -> OK, balance 0. Then withdraw 0 -> ZERO_AMT (101).
- Three wrong PINs on acct 2 -> BAD_PIN three times. Fourth request with correct PIN -> LOCKED (010), balance 0. cfg_we on acct 2 with PIN 1010, balance 5, then auth with 1010 -> OK, balance 5.
- Two wrong PINs, then a correct PIN, then two wrong PINs on acct 3 -> never locks; the try counter clears on success.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, status and balance held stable, req_ready=0. Assert rst_n=0 during EXEC of a deposit -> balance unchanged after reset release.
